oflow_iou_best_match: RTL and testbench
=======================================

# oflow_iou_best_match

Match-selection stage directly downstream of the IoU distance calculator. For one current-frame bbox it walks the history bboxes, pulses the calculator once per candidate, and keeps the candidate with the smallest IoU distance (`iou` = 1 − IoU). When the scan ends it reports the winning index, its distance and a threshold verdict. This result feeds the object-ID assignment logic.

## Interface

Parameters:
- IOU_LEN, 11: width of the IoU distance value.
- MAX_HIST, 8: maximum number of history candidates.
- IDX_W, $clog2(MAX_HIST): candidate index width.
- CNT_W, $clog2(MAX_HIST+1): candidate count width.
- TIMEOUT, 15: maximum WAIT cycles per candidate.

Ports:
- clk  in  1  clock.
- reset_N  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan; ignored while busy.
- num_hist  in  CNT_W  number of valid candidates (0..MAX_HIST); sampled with start.
- iou_threshold  in  IOU_LEN  acceptance limit; sampled with start.
- calc_start  out  1  one-cycle pulse to the IoU calculator.
- hist_idx  out  IDX_W  index of the candidate in flight; drives the history bbox mux.
- valid_iou  in  1  result strobe from the calculator.
- iou  in  IOU_LEN  distance; valid when valid_iou is high.
- busy  out  1  high from the cycle after start until done, inclusive.
- done  out  1  one-cycle pulse; results are valid.
- best_idx  out  IDX_W  index of the minimum-distance candidate.
- best_iou  out  IOU_LEN  the minimum distance.
- match_found  out  1  best_iou <= threshold and at least one result was received.
- timeout_err  out  1  sticky; a candidate timed out during this scan.

## Operation

- FSM states and transitions:
  - IDLE → ISSUE on start when num_hist ≠ 0.
  - IDLE → DONE on start when num_hist = 0.
  - ISSUE → WAIT after exactly one cycle.
  - WAIT → ISSUE on valid_iou (or timeout) when hist_idx < num_hist−1; hist_idx increments.
  - WAIT → DONE on valid_iou (or timeout) for the last candidate.
  - DONE → IDLE after one cycle.
- On accepted start:
  - Latch num_hist and threshold.
  - hist_idx ← 0, best_iou ← all ones, best_idx ← 0, got_any ← 0.
  - timeout_err ← 0, match_found ← 0.
- calc_start = (state == ISSUE). busy = (state ≠ IDLE). done = (state == DONE).
- Compare rule in WAIT on valid_iou: update best when iou < best_iou (unsigned, strict), or when this is the first result. Ties keep the lower index.
- hist_idx is held stable from ISSUE until the cycle WAIT exits.
- Watchdog: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT without valid_iou:
  - set timeout_err,
  - leave best unchanged,
  - advance as if a result had arrived.
- match_found is registered on the transition into DONE: got_any && best_iou <= threshold_latched.
- valid_iou outside WAIT is ignored. start outside IDLE is ignored.
- best_idx, best_iou, match_found and timeout_err hold from done until the next accepted start.

## Timing

- Reset (any time, including mid-scan): state = IDLE. All outputs are 0: calc_start, hist_idx, busy, done, best_idx, best_iou, match_found, timeout_err. The watchdog counter is 0.
- start sampled at edge 0 → calc_start high in cycle 1 with hist_idx = 0.
- Calculator latency L is measured from calc_start to valid_iou. With valid_iou in cycle c, the next calc_start is in cycle c+1.
- done is high in the cycle after the last valid_iou (or last timeout) is sampled.
- Scan latency from start to done = num_hist·(L+1)+1 cycles. For num_hist = 0, done is high in cycle 1.
- A valid_iou arriving in the same cycle the watchdog expires counts as a result, not a timeout.

## Test plan

- num_hist=3, threshold=400, L=5, iou={700,250,300} → calc_start in cycles 1, 7, 13; done in cycle 19; best_idx=1, best_iou=250, match_found=1.
- num_hist=2, iou={512,512} → best_idx=0 (tie keeps lower index); with threshold=511, match_found=0.
- num_hist=0 → no calc_start; done in cycle 1; match_found=0, best_iou=2047.
- num_hist=2, first candidate never returns valid_iou → after 15 WAIT cycles, timeout_err=1 and the second calc_start issues; second iou=100 → best_idx=1, best_iou=100.
- Second start pulsed mid-scan and a stray valid_iou in IDLE → both ignored; results identical to an undisturbed run.
- reset_N asserted in WAIT with hist_idx=2 → all outputs 0 immediately; a fresh start then runs correctly from hist_idx=0.

Source files
------------

// File: rtl/oflow_iou_best_match.sv
// rtl/oflow_iou_best_match.sv - scans history bboxes and keeps the minimum IoU distance candidate
module oflow_iou_best_match #(
    parameter int IOU_LEN  = 11,
    parameter int MAX_HIST = 8,
    parameter int IDX_W    = $clog2(MAX_HIST),
    parameter int CNT_W    = $clog2(MAX_HIST + 1),
    parameter int TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_hist,
    input  logic [IOU_LEN-1:0] iou_threshold,
    output logic               calc_start,
    output logic [IDX_W-1:0]   hist_idx,
    input  logic               valid_iou,
    input  logic [IOU_LEN-1:0] iou,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   best_idx,
    output logic [IOU_LEN-1:0] best_iou,
    output logic               match_found,
    output logic               timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [IOU_LEN-1:0] thr_q, thr_d;
    logic [IDX_W-1:0]   hist_idx_q, hist_idx_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [IOU_LEN-1:0] best_iou_q, best_iou_d;
    logic               got_any_q, got_any_d;
    logic               match_q, match_d;
    logic               tout_q, tout_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               advance;
    logic               last_cand;

    // The candidate in flight is the last one when idx+1 reaches the latched count.
    assign last_cand = (CNT_W'(hist_idx_q) + CNT_W'(1)) >= num_q;

    // Next-state, scan bookkeeping and best-candidate tracking.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        thr_d      = thr_q;
        hist_idx_d = hist_idx_q;
        best_idx_d = best_idx_q;
        best_iou_d = best_iou_q;
        got_any_d  = got_any_q;
        match_d    = match_q;
        tout_d     = tout_q;
        wd_d       = wd_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_hist;
                    thr_d      = iou_threshold;
                    hist_idx_d = '0;
                    best_idx_d = '0;
                    best_iou_d = '1;
                    got_any_d  = 1'b0;
                    tout_d     = 1'b0;
                    match_d    = 1'b0;
                    if (num_hist == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result in the expiry cycle wins over the watchdog.
                if (valid_iou) begin
                    advance   = 1'b1;
                    got_any_d = 1'b1;
                    if (!got_any_q || (iou < best_iou_q)) begin
                        best_iou_d = iou;
                        best_idx_d = hist_idx_q;
                    end
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    advance = 1'b1;
                    tout_d  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end

                if (advance) begin
                    if (last_cand) begin
                        state_d = S_DONE;
                        match_d = got_any_d && (best_iou_d <= thr_q);
                    end else begin
                        hist_idx_d = hist_idx_q + IDX_W'(1);
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            thr_q      <= '0;
            hist_idx_q <= '0;
            best_idx_q <= '0;
            best_iou_q <= '0;
            got_any_q  <= 1'b0;
            match_q    <= 1'b0;
            tout_q     <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            thr_q      <= thr_d;
            hist_idx_q <= hist_idx_d;
            best_idx_q <= best_idx_d;
            best_iou_q <= best_iou_d;
            got_any_q  <= got_any_d;
            match_q    <= match_d;
            tout_q     <= tout_d;
            wd_q       <= wd_d;
        end
    end

    assign calc_start  = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign hist_idx    = hist_idx_q;
    assign best_idx    = best_idx_q;
    assign best_iou    = best_iou_q;
    assign match_found = match_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_oflow_iou_best_match.sv
// tb/tb_oflow_iou_best_match.sv - directed self-checking bench for oflow_iou_best_match
module tb_oflow_iou_best_match;

    logic        clk;
    logic        reset_N;
    logic        start;
    logic [3:0]  num_hist;
    logic [10:0] iou_threshold;
    logic        calc_start;
    logic [2:0]  hist_idx;
    logic        valid_iou;
    logic [10:0] iou;
    logic        busy;
    logic        done;
    logic [2:0]  best_idx;
    logic [10:0] best_iou;
    logic        match_found;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    int ivals[8];
    bit noresp[8];
    int extra_start;
    int stray_valid;
    int abort_idx;

    int calc_cyc[$];
    int done_cyc;
    int r_idx, r_iou, r_match, r_tout, r_busy;
    int p_idx, p_iou, p_match;
    int rst_word;
    bit aborted;

    oflow_iou_best_match dut (
        .clk          (clk),
        .reset_N      (reset_N),
        .start        (start),
        .num_hist     (num_hist),
        .iou_threshold(iou_threshold),
        .calc_start   (calc_start),
        .hist_idx     (hist_idx),
        .valid_iou    (valid_iou),
        .iou          (iou),
        .busy         (busy),
        .done         (done),
        .best_idx     (best_idx),
        .best_iou     (best_iou),
        .match_found  (match_found),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cc(input int i);
        return (i < calc_cyc.size()) ? calc_cyc[i] : -1;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < 8; i++) begin
            ivals[i]  = 0;
            noresp[i] = 1'b0;
        end
        extra_start = -1;
        stray_valid = -1;
        abort_idx   = -1;
    endtask

    // Cycle n is the period ending at edge n; start is high in cycle 0.
    // The calculator model answers L cycles after each observed calc_start.
    task automatic run_scan(input int num, input int thr, input int lat);
        int cyc;
        int pend;
        int pval;
        bit fin;
        calc_cyc.delete();
        done_cyc = -1;
        aborted  = 1'b0;
        pend     = -1;
        pval     = 0;
        cyc      = 0;
        fin      = 1'b0;
        @(negedge clk);
        start         = 1'b1;
        num_hist      = 4'(num);
        iou_threshold = 11'(thr);
        valid_iou     = 1'b0;
        iou           = '0;
        while (!fin && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start     = 1'b0;
            valid_iou = 1'b0;
            iou       = '0;
            if (cyc == extra_start) begin
                start         = 1'b1;
                num_hist      = 4'd1;
                iou_threshold = 11'd0;
            end
            if (calc_start) begin
                calc_cyc.push_back(cyc);
                if (!noresp[hist_idx]) begin
                    pend = cyc + lat;
                    pval = ivals[hist_idx];
                end
            end
            if (cyc == pend) begin
                valid_iou = 1'b1;
                iou       = 11'(pval);
            end
            if (cyc == stray_valid) begin
                valid_iou = 1'b1;
                iou       = 11'd1;
            end
            if (done) begin
                done_cyc = cyc;
                r_idx    = int'(best_idx);
                r_iou    = int'(best_iou);
                r_match  = int'(match_found);
                r_tout   = int'(timeout_err);
                r_busy   = int'(busy);
            end
            if (abort_idx >= 0 && busy && !calc_start && !done && int'(hist_idx) == abort_idx) begin
                reset_N   = 1'b1;
                start     = 1'b0;
                valid_iou = 1'b0;
                #1;
                rst_word = int'({calc_start, hist_idx, busy, done, best_idx,
                                 best_iou, match_found, timeout_err});
                aborted  = 1'b1;
                fin      = 1'b1;
            end
            if (done_cyc >= 0 && cyc >= stray_valid + 1) fin = 1'b1;
        end
        start     = 1'b0;
        valid_iou = 1'b0;
        p_idx   = int'(best_idx);
        p_iou   = int'(best_iou);
        p_match = int'(match_found);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        reset_N       = 1'b1;
        start         = 1'b0;
        num_hist      = '0;
        iou_threshold = '0;
        valid_iou     = 1'b0;
        iou           = '0;
        clear_cfg();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {calc_start, hist_idx, busy, done, best_idx,
                           best_iou, match_found, timeout_err}, 0);
        @(negedge clk);
        reset_N = 1'b0;

        // Basic three-candidate scan.
        clear_cfg();
        ivals[0] = 700; ivals[1] = 250; ivals[2] = 300;
        run_scan(3, 400, 5);
        check("t1_ncalc", calc_cyc.size(), 3);
        check("t1_calc0", cc(0), 1);
        check("t1_calc1", cc(1), 7);
        check("t1_calc2", cc(2), 13);
        check("t1_done", done_cyc, 19);
        check("t1_idx", r_idx, 1);
        check("t1_iou", r_iou, 250);
        check("t1_match", r_match, 1);
        check("t1_tout", r_tout, 0);
        check("t1_busy_at_done", r_busy, 1);

        // Tie keeps the lower index; threshold just below.
        clear_cfg();
        ivals[0] = 512; ivals[1] = 512;
        run_scan(2, 511, 2);
        check("t2_calc1", cc(1), 4);
        check("t2_done", done_cyc, 7);
        check("t2_idx", r_idx, 0);
        check("t2_iou", r_iou, 512);
        check("t2_match", r_match, 0);

        // Empty history.
        clear_cfg();
        run_scan(0, 400, 2);
        check("t3_ncalc", calc_cyc.size(), 0);
        check("t3_done", done_cyc, 1);
        check("t3_iou", r_iou, 2047);
        check("t3_match", r_match, 0);
        check("t3_idx", r_idx, 0);

        // First candidate never answers; watchdog expires after 15 WAIT cycles.
        clear_cfg();
        noresp[0] = 1'b1;
        ivals[1]  = 100;
        run_scan(2, 400, 3);
        check("t4_calc1", cc(1), 17);
        check("t4_done", done_cyc, 21);
        check("t4_tout", r_tout, 1);
        check("t4_idx", r_idx, 1);
        check("t4_iou", r_iou, 100);
        check("t4_match", r_match, 1);

        // Mid-scan start and stray valid_iou in IDLE are ignored.
        clear_cfg();
        ivals[0] = 700; ivals[1] = 250; ivals[2] = 300;
        extra_start = 3;
        stray_valid = 21;
        run_scan(3, 400, 5);
        check("t5_ncalc", calc_cyc.size(), 3);
        check("t5_calc2", cc(2), 13);
        check("t5_done", done_cyc, 19);
        check("t5_idx", r_idx, 1);
        check("t5_match", r_match, 1);
        check("t5_hold_iou", p_iou, 250);
        check("t5_hold_idx", p_idx, 1);
        check("t5_hold_match", p_match, 1);

        // Reset while waiting on candidate 2, then a fresh scan.
        clear_cfg();
        ivals[0] = 700; ivals[1] = 250; ivals[2] = 300;
        abort_idx = 2;
        run_scan(3, 400, 5);
        check("t6_aborted", aborted, 1);
        check("t6_rst_outs", rst_word, 0);
        @(negedge clk);
        reset_N = 1'b0;
        clear_cfg();
        ivals[0] = 90; ivals[1] = 40;
        run_scan(2, 50, 2);
        check("t6_calc0", cc(0), 1);
        check("t6_calc1", cc(1), 4);
        check("t6_done", done_cyc, 7);
        check("t6_idx", r_idx, 1);
        check("t6_iou", r_iou, 40);
        check("t6_match", r_match, 1);
        check("t6_tout", r_tout, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
